// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit: MEM-stage load/store engine with a req/ack bus handshake.   |
// | Optional MISALIGN_EXC_EN macro raises misalign instead of forcing alignment. |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int BUS_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q, wdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             err_q, err_d, mis_q, mis_d;

  logic             w_timeout, w_misaligned;
  logic [31:0]      w_addr_al, w_fmt, w_wdata_rep;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [3:0]       w_strb;

  // Size 2'b11 behaves as a word everywhere, so size[1] alone means "word".
`ifdef MISALIGN_EXC_EN
  assign w_misaligned = req_size[1] ? (req_addr[1:0] != 2'b00) : (req_size[0] & req_addr[0]);
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    w_addr_al = req_addr;
    if (req_size[1])      w_addr_al[1:0] = 2'b00;
    else if (req_size[0]) w_addr_al[0]   = 1'b0;
  end

  generate
    if (BUS_TIMEOUT != 0) begin : g_timeout
      assign w_timeout = (state_q == S_REQ) && !bus_ack &&
                         (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = w_misaligned ? S_DONE : S_REQ;
      S_REQ:   if (bus_ack || w_timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   w_fmt = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_fmt = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   w_strb = 4'b0001 << addr_q[1:0];
      2'b01:   w_strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
    case (size_q)
      2'b00:   w_wdata_rep = {4{wdata_q[7:0]}};
      2'b01:   w_wdata_rep = {2{wdata_q[15:0]}};
      default: w_wdata_rep = wdata_q;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    ld_data_d = ld_data_q;
    err_d     = w_timeout;
    mis_d     = (state_q == S_IDLE) && req_valid && w_misaligned;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_REQ) begin
      if (bus_ack) begin
        if (!we_q) ld_data_d = w_fmt;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (w_timeout) ld_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= w_addr_al;
        wdata_q <= req_wdata;
      end
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  // Bus signals are gated to the REQ state so nothing leaks onto the bus otherwise.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wstrb = 4'b0000;
    bus_wdata = '0;
    done      = 1'b0;
    bus_err   = 1'b0;
    misalign  = 1'b0;
    stall     = rst_n && (state_q == S_IDLE) && req_valid;
    case (state_q)
      S_REQ: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_wstrb = we_q ? w_strb : 4'b0000;
        bus_wdata = w_wdata_rep;
        stall     = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        bus_err  = err_q;
        misalign = mis_q;
      end
      default: ;
    endcase
  end

  assign ld_data = ld_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit: directed + randomized bench with a behavioural model.    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        stall, done, bus_err, misalign;
  logic [31:0] ld_data;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_ld   = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .ld_data(ld_data), .done(done),
    .bus_err(bus_err), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] eff_addr(input logic [1:0] sz, input logic [31:0] a);
    return a - (a % nbytes(sz));
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    int lane;
    lane = int'(eff_addr(sz, a) % 4);
    return 4'(((1 << nbytes(sz)) - 1) << lane);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (nbytes(sz) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (nbytes(sz) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic uns, input logic [31:0] rd);
    int nb, sh;
    logic [31:0] v, mask;
    nb = nbytes(sz);
    if (nb == 4) return rd;
    sh   = 8 * int'(eff_addr(sz, a) % 4);
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = (rd >> sh) & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd);
    bit          mis, timed_out;
    logic [31:0] ea;
    int          k;
    ea = eff_addr(sz, a);
`ifdef MISALIGN_EXC_EN
    mis = (a % nbytes(sz)) != 0;
`else
    mis = 1'b0;
`endif
    @(negedge clk);
    bus_ack = 1'b0; req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    #1;
    check("stall_issue", 32'(stall), 1);
    check("ld_hold_idle", ld_data, exp_ld);
    @(negedge clk);
    // Upstream keeps req_valid high while stalled; scrambled fields must not matter.
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_we = 1'($urandom); req_unsigned = 1'($urandom);
    timed_out = 1'b0;
    if (!mis) begin
      k = 0;
      forever begin
        check("bus_req", 32'(bus_req), 1);
        check("bus_we", 32'(bus_we), 32'(we));
        check("bus_addr", bus_addr, {ea[31:2], 2'b00});
        check("bus_wstrb", 32'(bus_wstrb), we ? 32'(model_strb(sz, a)) : 0);
        if (we) check("bus_wdata", bus_wdata, model_wdata(sz, wd));
        check("stall_req", 32'(stall), 1);
        if (k == dly) begin
          bus_ack = 1'b1; bus_rdata = rd;
          @(negedge clk);
          bus_ack = 1'b0; bus_rdata = $urandom;
          break;
        end
        @(negedge clk);
        k++;
        if (k == TO) begin
          timed_out = 1'b1;
          break;
        end
      end
      if (timed_out)  exp_ld = '0;
      else if (!we)   exp_ld = model_load(sz, a, uns, rd);
    end
    check("done", 32'(done), 1);
    check("bus_err", 32'(bus_err), 32'(timed_out));
    check("misalign", 32'(misalign), 32'(mis));
    check("stall_done", 32'(stall), 0);
    check("bus_req_done", 32'(bus_req), 0);
    check("ld_data", ld_data, exp_ld);
    req_valid = 1'b0;
    if (timed_out) begin
      bus_ack = 1'b1; bus_rdata = $urandom;
    end
    @(negedge clk);
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    check("done_pulse", 32'(done), 0);
    check("bus_req_idle", 32'(bus_req), 0);
    check("ld_after", ld_data, exp_ld);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_done", 32'(done), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_wstrb", 32'(bus_wstrb), 0);
    rst_n = 1'b1;

    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_result", ld_data, 32'hDEADBEEF);
    do_access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 1, 32'h80123456);
    check("lb_signed", ld_data, 32'hFFFFFF80);
    do_access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 0, 32'h80123456);
    check("lbu", ld_data, 32'h00000080);
    do_access(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000ABCD, 3, 32'h12345678);
    check("sh_ld_hold", ld_data, 32'h00000080);
    do_access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 99, 32'h0);
    check("timeout_ld", ld_data, 32'h0);
    do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'hCAFEF00D);
    do_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 2, 32'h9ABC1234);

    // Reset during an outstanding access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h400;
    @(negedge clk);
    check("pre_rst_bus_req", 32'(bus_req), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_bus_req", 32'(bus_req), 0);
    check("async_stall", 32'(stall), 0);
    check("async_done", 32'(done), 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ld = '0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("stale_ack_done", 32'(done), 0);
    check("stale_ack_req", 32'(bus_req), 0);
    check("stale_ack_ld", ld_data, 0);

    for (int i = 0; i < 250; i++) begin
      logic we;
      we = 1'($urandom);
      do_access(we, 2'($urandom), 1'($urandom), $urandom, $urandom,
                we ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 6)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
